pack_serializer: RTL and testbench

- Packet framer/serializer: accepts a fixed-size payload as bytes on a valid/ready input, emits a serial bitstream of a fixed 32-bit preamble followed by the payload bits on a valid/ready output.
- Sits between the byte-oriented packet source and the bit-serial modulator path.
- Payload buffering and draining may overlap: payload bits stream out as soon as their byte has been written.

---
 rtl/pack_serializer_if.sv | 14 +
 rtl/pack_serializer.sv | 76 +++++++
 tb/tb_pack_serializer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pack_serializer_if.sv
// pack_serializer_if: byte-in / beat-out valid-ready bus for pack_serializer
interface pack_serializer_if #(
  parameter int SIZE_INPUT_BIT  = 8,
  parameter int SIZE_OUTPUT_BIT = 1
);
  logic                       o_ready;
  logic [SIZE_INPUT_BIT-1:0]  i_data;
  logic                       i_valid_input;
  logic                       i_ready_output;
  logic [SIZE_OUTPUT_BIT-1:0] o_data;
  logic                       o_valid;
  modport slave (output o_ready, o_data, o_valid, input i_data, i_valid_input, i_ready_output);
  modport master (input o_ready, o_data, o_valid, output i_data, i_valid_input, i_ready_output);
endinterface

// File: rtl/pack_serializer.sv
// pack_serializer: frames buffered payload bytes behind a fixed preamble as a serial stream; PACK_LSB_FIRST_EN sends each input-width group LSB first
module pack_serializer #(
  parameter int                     SIZE_BIT_PACK   = 1976,
  parameter int                     SIZE_INPUT_BIT  = 8,
  parameter int                     SIZE_OUTPUT_BIT = 1,
  parameter int                     SIZE_PREAMBLE   = 32,
  parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE      = 32'hCF80AA31
) (
  input logic              i_clk,
  input logic              i_reset,
  pack_serializer_if.slave io_bus
);
  localparam int LENGTH_INPUT = SIZE_BIT_PACK / SIZE_INPUT_BIT;
  localparam int ADDR_W = $clog2(LENGTH_INPUT);
  localparam int PTR_W = $clog2(LENGTH_INPUT + 1);
  localparam int CNT_W = $clog2(SIZE_BIT_PACK > SIZE_PREAMBLE ? SIZE_BIT_PACK : SIZE_PREAMBLE);
  localparam logic [0:0] ST_PREAMBLE = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;
  localparam logic [CNT_W-1:0] STEP = CNT_W'(SIZE_OUTPUT_BIT);
  localparam logic [CNT_W-1:0] GROUP = CNT_W'(SIZE_INPUT_BIT);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(SIZE_PREAMBLE - SIZE_OUTPUT_BIT);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(SIZE_BIT_PACK - SIZE_OUTPUT_BIT);
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(LENGTH_INPUT);

  logic [SIZE_INPUT_BIT-1:0] r_mem [LENGTH_INPUT];
  logic                      r_run;
  logic [0:0]                r_state;
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [CNT_W-1:0]          r_cnt;
  logic [PTR_W-1:0]          w_rd_byte;
  logic [SIZE_INPUT_BIT-1:0] w_word, w_word_line, w_word_shift;
  logic [SIZE_PREAMBLE-1:0]  w_pre_line, w_pre_shift;
  logic                      w_valid, w_ready, w_fire, w_write, w_last;

  assign w_rd_byte = PTR_W'(r_cnt / GROUP);
  assign w_word = r_mem[w_rd_byte[ADDR_W-1:0]];
`ifdef PACK_LSB_FIRST_EN
  assign w_word_line = {<<{w_word}};
  assign w_pre_line = {<<SIZE_INPUT_BIT{{<<{PREAMBLE}}}};
`else
  assign w_word_line = w_word;
  assign w_pre_line = PREAMBLE;
`endif
  assign w_pre_shift = w_pre_line << r_cnt;
  assign w_word_shift = w_word_line << (r_cnt % GROUP);
  // payload beats only go out once their byte has landed in the buffer
  assign w_valid = r_state == ST_PREAMBLE ? r_run : w_rd_byte < r_wr_ptr;
  assign w_ready = r_run && r_wr_ptr < PTR_FULL;
  assign w_fire = w_valid && io_bus.i_ready_output;
  assign w_write = io_bus.i_valid_input && w_ready;
  assign w_last = r_cnt == (r_state == ST_PREAMBLE ? PRE_LAST : PAY_LAST);
  assign io_bus.o_valid = w_valid;
  assign io_bus.o_ready = w_ready;
  assign io_bus.o_data = !w_valid ? '0 :
                         r_state == ST_PREAMBLE ? w_pre_shift[SIZE_PREAMBLE-1 -: SIZE_OUTPUT_BIT] :
                         w_word_shift[SIZE_INPUT_BIT-1 -: SIZE_OUTPUT_BIT];

  always_ff @(posedge i_clk)
    if (w_write) r_mem[r_wr_ptr[ADDR_W-1:0]] <= io_bus.i_data;

  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      r_run <= 1'b0;
      r_state <= ST_PREAMBLE;
      r_wr_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_write) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_fire) begin
        r_cnt <= w_last ? '0 : r_cnt + STEP;
        if (w_last) r_state <= ~r_state;
        if (w_last && r_state == ST_PAYLOAD) r_wr_ptr <= '0;
      end
    end
endmodule

// File: tb/tb_pack_serializer.sv
// tb_pack_serializer: randomized and directed checks of pack_serializer against a bit-queue line model
module tb_pack_serializer;
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic [31:0] pre_v = 32'hCF80AA31;
  int total = 0;
  int bad = 0;

  pack_serializer_if #(.SIZE_INPUT_BIT(8), .SIZE_OUTPUT_BIT(1)) bus ();
  pack_serializer dut (.i_clk(i_clk), .i_reset(i_reset), .io_bus(bus));

  always #5 i_clk = ~i_clk;

  function automatic logic pre_bit(input int k);
`ifdef PACK_LSB_FIRST_EN
    return pre_v[8 * (3 - k / 8) + k % 8];
`else
    return pre_v[31 - k];
`endif
  endfunction

  function automatic logic word_bit(input logic [7:0] w, input int j);
`ifdef PACK_LSB_FIRST_EN
    return w[j];
`else
    return w[7 - j];
`endif
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_valid_input = 1'b0;
    bus.i_data = 8'h00;
    bus.i_ready_output = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 1'b0;
    step();
    step();
    i_reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    #2;
    i_reset = 1'b0;
    step();
    step();
    total += 3;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.o_valid); end
    if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.o_ready); end
    if (bus.o_data !== 1'b0) begin bad++; $display("FAIL reset_data got=%b want=0", bus.o_data); end
    i_reset = 1'b1;
    step();
    total += 3;
    if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL release_valid got=%b want=1", bus.o_valid); end
    if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", bus.o_ready); end
    if (bus.o_data !== pre_bit(0)) begin bad++; $display("FAIL release_data got=%b want=%b", bus.o_data, pre_bit(0)); end
  endtask

  task automatic test_preamble_idle();
    do_reset();
    for (int k = 0; k < 33; k++) begin
      bus.i_ready_output = 1'b1;
      total++;
      if (bus.o_valid !== (k < 32)) begin bad++; $display("FAIL idle_valid beat=%0d got=%b want=%b", k, bus.o_valid, k < 32); end
      if (k < 32) begin
        total++;
        if (bus.o_data !== pre_bit(k)) begin bad++; $display("FAIL idle_pre beat=%0d got=%b want=%b", k, bus.o_data, pre_bit(k)); end
      end
      step();
      bus.i_ready_output = 1'b0;
      step();
    end
    idle_inputs();
  endtask

  task automatic run_frame(input int vpct, input int rpct, input bit rnd, input logic [7:0] fdata);
    logic q[$];
    int acc = 0;
    int beats = 0;
    int cyc = 0;
    logic b;
    do_reset();
    for (int k = 0; k < 32; k++) q.push_back(pre_bit(k));
    while (beats < 2008 && cyc < 20000) begin
      bus.i_valid_input = (acc < 247) && ($urandom_range(99) < vpct);
      bus.i_data = rnd ? 8'($urandom) : fdata;
      bus.i_ready_output = $urandom_range(99) < rpct;
      total += 2;
      if (bus.o_valid !== (q.size() > 0)) begin bad++; $display("FAIL frame_valid beat=%0d got=%b want=%b", beats, bus.o_valid, q.size() > 0); end
      if (bus.o_ready !== (acc < 247)) begin bad++; $display("FAIL frame_ready acc=%0d got=%b want=%b", acc, bus.o_ready, acc < 247); end
      if (bus.o_valid && bus.i_ready_output) begin
        b = q.size() > 0 ? q.pop_front() : ~bus.o_data[0];
        total++;
        if (bus.o_data !== b) begin bad++; $display("FAIL frame_bit beat=%0d got=%b want=%b", beats, bus.o_data, b); end
        beats++;
      end
      if (bus.i_valid_input && bus.o_ready) begin
        acc++;
        for (int j = 0; j < 8; j++) q.push_back(word_bit(bus.i_data, j));
      end
      step();
      cyc++;
    end
    total++;
    if (beats != 2008) begin bad++; $display("FAIL frame_timeout beats=%0d want=2008", beats); end
    idle_inputs();
    total += 3;
    if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL restart_ready got=%b want=1", bus.o_ready); end
    if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL restart_valid got=%b want=1", bus.o_valid); end
    if (bus.o_data !== pre_bit(0)) begin bad++; $display("FAIL restart_data got=%b want=%b", bus.o_data, pre_bit(0)); end
  endtask

  task automatic test_full_frame();
    run_frame(100, 100, 1'b0, 8'h81);
  endtask

  task automatic test_random_frame();
    run_frame(60, 70, 1'b1, 8'h00);
    run_frame(90, 40, 1'b1, 8'h00);
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.i_ready_output = 1'b1;
    repeat (10) step();
    bus.i_ready_output = 1'b0;
    for (int c = 0; c < 10; c++) begin
      total += 2;
      if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b want=1", c, bus.o_valid); end
      if (bus.o_data !== pre_bit(10)) begin bad++; $display("FAIL hold_data cyc=%0d got=%b want=%b", c, bus.o_data, pre_bit(10)); end
      step();
    end
    bus.i_ready_output = 1'b1;
    for (int k = 10; k < 32; k++) begin
      total++;
      if (bus.o_data !== pre_bit(k)) begin bad++; $display("FAIL resume_data beat=%0d got=%b want=%b", k, bus.o_data, pre_bit(k)); end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_single_word();
    logic [7:0] w = 8'hA5;
    do_reset();
    bus.i_ready_output = 1'b1;
    repeat (32) step();
    repeat (3) begin
      total++;
      if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL empty_valid got=%b want=0", bus.o_valid); end
      step();
    end
    bus.i_valid_input = 1'b1;
    bus.i_data = w;
    total++;
    if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", bus.o_ready); end
    step();
    bus.i_valid_input = 1'b0;
    for (int j = 0; j < 8; j++) begin
      total += 2;
      if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL single_valid bit=%0d got=%b want=1", j, bus.o_valid); end
      if (bus.o_data !== word_bit(w, j)) begin bad++; $display("FAIL single_bit bit=%0d got=%b want=%b", j, bus.o_data, word_bit(w, j)); end
      step();
    end
    total++;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL single_after got=%b want=0", bus.o_valid); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    int cyc = 0;
    do_reset();
    bus.i_ready_output = 1'b1;
    bus.i_valid_input = 1'b1;
    while (beats < 132 && cyc < 1000) begin
      bus.i_data = 8'($urandom);
      if (bus.o_valid) beats++;
      step();
      cyc++;
    end
    total++;
    if (beats != 132) begin bad++; $display("FAIL mid_timeout beats=%0d want=132", beats); end
    i_reset = 1'b0;
    #1;
    total += 3;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", bus.o_valid); end
    if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b want=0", bus.o_ready); end
    if (bus.o_data !== 1'b0) begin bad++; $display("FAIL mid_data got=%b want=0", bus.o_data); end
    bus.i_valid_input = 1'b0;
    step();
    i_reset = 1'b1;
    step();
    total++;
    if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL mid_rel_ready got=%b want=1", bus.o_ready); end
    for (int k = 0; k < 32; k++) begin
      total++;
      if (bus.o_data !== pre_bit(k) || bus.o_valid !== 1'b1) begin bad++; $display("FAIL mid_pre beat=%0d got=%b/%b want=%b/1", k, bus.o_data, bus.o_valid, pre_bit(k)); end
      step();
    end
    total++;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL mid_empty got=%b want=0", bus.o_valid); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_preamble_idle();
    test_full_frame();
    test_backpressure();
    test_single_word();
    test_reset_mid();
    test_random_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
